// File: rtl/uart_line_rx_pkg.sv
// Shared character constants, FSM encodings and byte classifiers for the UART line receiver.
package uart_line_rx_pkg;

    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_BS  = 8'h08;
    localparam logic [7:0] CHAR_DEL = 8'h7F;

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_DISCARD = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;

    function automatic logic is_term(input logic [7:0] b);
        return (b == CHAR_CR) || (b == CHAR_LF);
    endfunction

    function automatic logic is_bs(input logic [7:0] b);
        return (b == CHAR_BS) || (b == CHAR_DEL);
    endfunction

endpackage

// File: rtl/uart_line_rx_buf.sv
// Line storage: 1-write/1-read synchronous RAM (module line_buf), registered read port for block-RAM inference.
module line_buf #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/uart_line_rx.sv
// Assembles UART bytes into a CR/LF-terminated line held for a consumer until line_ack.
// Optional feature macro: UART_LINE_BACKSPACE_EN (0x08/0x7F erase the previous byte while collecting).
module uart_line_rx
    import uart_line_rx_pkg::*;
#(
    parameter int  MAX_LEN = 16,
    localparam int LEN_W   = $clog2(MAX_LEN + 1),
    localparam int ADDR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              received,
    input  logic [7:0]        rx_byte,
    input  logic              recv_error,
    output logic              line_valid,
    output logic [LEN_W-1:0]  line_len,
    output logic              line_overflow,
    output logic              overrun,
    input  logic              line_ack,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

`ifdef UART_LINE_BACKSPACE_EN
    localparam logic BS_EN = 1'b1;
`else
    localparam logic BS_EN = 1'b0;
`endif

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;
    logic             overrun_q, overrun_d;

    logic [1:0]       st_eff;
    logic [LEN_W-1:0] len_eff;
    logic             ovf_eff;
    logic             ovr_eff;
    logic             wr_en;
    logic             term_hit;
    logic             bs_hit;

    assign term_hit = is_term(rx_byte);
    assign bs_hit   = BS_EN && is_bs(rx_byte);

    always_comb begin
        // An ack in READY releases the line first, so a coincident byte starts the next line.
        st_eff  = state_q;
        len_eff = len_q;
        ovf_eff = ovf_q;
        ovr_eff = overrun_q;
        if (state_q == ST_READY && line_ack) begin
            st_eff  = ST_COLLECT;
            len_eff = '0;
            ovf_eff = 1'b0;
            ovr_eff = 1'b0;
        end

        state_d   = st_eff;
        len_d     = len_eff;
        ovf_d     = ovf_eff;
        overrun_d = ovr_eff;
        wr_en     = 1'b0;

        case (st_eff)
            ST_COLLECT: begin
                if (recv_error) begin
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_DISCARD;
                end else if (received) begin
                    if (term_hit) begin
                        if (len_eff != '0) begin
                            state_d = ST_READY;
                        end
                    end else if (bs_hit) begin
                        if (len_eff != '0) begin
                            len_d = len_eff - LEN_W'(1);
                        end
                    end else if (len_eff == MAX_LEN_L) begin
                        ovf_d   = 1'b1;
                        state_d = ST_DISCARD;
                    end else begin
                        wr_en = 1'b1;
                        len_d = len_eff + LEN_W'(1);
                    end
                end
            end
            ST_DISCARD: begin
                // len is still MAX_LEN after an overflow, so the truncated line is delivered as-is.
                if (received && term_hit) begin
                    if (ovf_eff) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_COLLECT;
                        len_d   = '0;
                    end
                end
            end
            ST_READY: begin
                if (received && !term_hit) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_COLLECT;
                len_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_COLLECT;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            ovf_q     <= ovf_d;
            overrun_q <= overrun_d;
        end
    end

    line_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_line_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en && !rst),
        .waddr (len_eff[ADDR_W-1:0]),
        .wdata (rx_byte),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign line_valid    = (state_q == ST_READY);
    assign line_len      = len_q;
    assign line_overflow = (state_q == ST_READY) && ovf_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_line_rx.sv
// Directed table-driven bench for uart_line_rx (MAX_LEN=16) plus overflow/boundary sequences.
module tb_uart_line_rx;

    localparam logic [7:0] K_A  = 8'h41;
    localparam logic [7:0] K_B  = 8'h42;
    localparam logic [7:0] K_C  = 8'h43;
    localparam logic [7:0] K_D  = 8'h44;
    localparam logic [7:0] K_M  = 8'h4D;
    localparam logic [7:0] K_Q  = 8'h51;
    localparam logic [7:0] K_X  = 8'h58;
    localparam logic [7:0] K_Y  = 8'h59;
    localparam logic [7:0] K_Z  = 8'h5A;
    localparam logic [7:0] K_CR = 8'h0D;
    localparam logic [7:0] K_LF = 8'h0A;
    localparam logic [7:0] K_BS = 8'h08;

`ifdef UART_LINE_BACKSPACE_EN
    localparam logic [4:0] BS_LEN = 5'd2;
    localparam logic [7:0] BS_D1  = K_C;
`else
    localparam logic [4:0] BS_LEN = 5'd4;
    localparam logic [7:0] BS_D1  = K_B;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       received;
    logic [7:0] rx_byte;
    logic       recv_error;
    logic       line_valid;
    logic [4:0] line_len;
    logic       line_overflow;
    logic       overrun;
    logic       line_ack;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;

    int checks   = 0;
    int failures = 0;
    int cur_row  = -1;

    always #5 clk = ~clk;

    uart_line_rx #(.MAX_LEN(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .received      (received),
        .rx_byte       (rx_byte),
        .recv_error    (recv_error),
        .line_valid    (line_valid),
        .line_len      (line_len),
        .line_overflow (line_overflow),
        .overrun       (overrun),
        .line_ack      (line_ack),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data)
    );

    typedef struct {
        logic       rs, rc;
        logic [7:0] b;
        logic       er, ak;
        logic [3:0] a;
        logic       cv, ev;
        logic [4:0] el;
        logic       eo, eov, cr;
        logic [7:0] ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic rs, input logic rc, input logic [7:0] b,
                               input logic er, input logic ak, input logic [3:0] a,
                               input logic cv, input logic ev, input logic [4:0] el,
                               input logic eo, input logic eov, input logic cr,
                               input logic [7:0] ed);
        vec_t t;
        t.rs = rs; t.rc = rc; t.b = b; t.er = er; t.ak = ak; t.a = a;
        t.cv = cv; t.ev = ev; t.el = el; t.eo = eo; t.eov = eov; t.cr = cr; t.ed = ed;
        return t;
    endfunction

    function automatic vec_t rxb(input logic [7:0] b, input logic ev, input logic [4:0] el,
                                 input logic eov);
        return v(1'b0, 1'b1, b, 1'b0, 1'b0, 4'd0, 1'b1, ev, el, 1'b0, eov, 1'b0, 8'h00);
    endfunction

    function automatic vec_t rdr(input logic [3:0] a, input logic ev, input logic [4:0] el,
                                 input logic eov, input logic [7:0] ed);
        return v(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, a, 1'b1, ev, el, 1'b0, eov, 1'b1, ed);
    endfunction

    function automatic vec_t ackr();
        return v(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0h exp=%0h", nm, cur_row, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic rc, input logic [7:0] b,
                         input logic er, input logic ak, input logic [3:0] a);
        rst = rs; received = rc; rx_byte = b; recv_error = er; line_ack = ak; rd_addr = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; received = 1'b0; rx_byte = 8'h00; recv_error = 1'b0;
        line_ack = 1'b0; rd_addr = 4'd0;

        // "AB\r\n", overrun while held, ack
        tbl.push_back(rxb(K_A, 1'b0, 5'd0, 1'b0));
        tbl.push_back(rxb(K_B, 1'b0, 5'd0, 1'b0));
        tbl.push_back(v(1'b0, 1'b1, K_CR, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, K_A));
        tbl.push_back(v(1'b0, 1'b1, K_LF, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, K_B));
        tbl.push_back(v(1'b0, 1'b1, K_X,  1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b1, 1'b1, K_A));
        tbl.push_back(rdr(4'd1, 1'b1, 5'd2, 1'b1, K_B));
        tbl.push_back(ackr());
        // "AB", framing error, "C\r", "D\r"
        tbl.push_back(rxb(K_A, 1'b0, 5'd0, 1'b0));
        tbl.push_back(rxb(K_B, 1'b0, 5'd0, 1'b0));
        tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00));
        tbl.push_back(rxb(K_C,  1'b0, 5'd0, 1'b0));
        tbl.push_back(rxb(K_CR, 1'b0, 5'd0, 1'b0));
        tbl.push_back(rxb(K_D,  1'b0, 5'd0, 1'b0));
        tbl.push_back(rxb(K_CR, 1'b1, 5'd1, 1'b0));
        tbl.push_back(rdr(4'd0, 1'b1, 5'd1, 1'b0, K_D));
        tbl.push_back(ackr());
        // blank LF ignored, "M\r", then ack coinciding with 'Q', then "\r"
        tbl.push_back(rxb(K_LF, 1'b0, 5'd0, 1'b0));
        tbl.push_back(rxb(K_M,  1'b0, 5'd0, 1'b0));
        tbl.push_back(rxb(K_CR, 1'b1, 5'd1, 1'b0));
        tbl.push_back(v(1'b0, 1'b1, K_Q, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00));
        tbl.push_back(rxb(K_CR, 1'b1, 5'd1, 1'b0));
        tbl.push_back(rdr(4'd0, 1'b1, 5'd1, 1'b0, K_Q));
        tbl.push_back(ackr());
        // "AB", BS, "C\r"
        tbl.push_back(rxb(K_A,  1'b0, 5'd0, 1'b0));
        tbl.push_back(rxb(K_B,  1'b0, 5'd0, 1'b0));
        tbl.push_back(rxb(K_BS, 1'b0, 5'd0, 1'b0));
        tbl.push_back(rxb(K_C,  1'b0, 5'd0, 1'b0));
        tbl.push_back(rxb(K_CR, 1'b1, BS_LEN, 1'b0));
        tbl.push_back(rdr(4'd0, 1'b1, BS_LEN, 1'b0, K_A));
        tbl.push_back(rdr(4'd1, 1'b1, BS_LEN, 1'b0, BS_D1));
        tbl.push_back(ackr());
        // reset mid-line (byte during reset dropped), "Z\r", reset while READY
        tbl.push_back(rxb(K_A, 1'b0, 5'd0, 1'b0));
        tbl.push_back(rxb(K_B, 1'b0, 5'd0, 1'b0));
        tbl.push_back(v(1'b1, 1'b1, K_Y, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 8'h00));
        tbl.push_back(rxb(K_Z,  1'b0, 5'd0, 1'b0));
        tbl.push_back(rxb(K_CR, 1'b1, 5'd1, 1'b0));
        tbl.push_back(rdr(4'd0, 1'b1, 5'd1, 1'b0, K_Z));
        tbl.push_back(v(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 8'h00));
        tbl.push_back(rxb(K_CR, 1'b0, 5'd0, 1'b0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   32'(line_valid),    32'd0);
        chk("rst_len",     32'(line_len),      32'd0);
        chk("rst_ovf",     32'(line_overflow), 32'd0);
        chk("rst_overrun", 32'(overrun),       32'd0);
        chk("rst_rd_data", 32'(rd_data),       32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t t;
            t = tbl[i];
            cur_row = i;
            drive(t.rs, t.rc, t.b, t.er, t.ak, t.a);
            if (t.cv) begin
                chk("valid",   32'(line_valid), 32'(t.ev));
                chk("overrun", 32'(overrun),    32'(t.eov));
                if (t.ev || t.rs) begin
                    chk("len", 32'(line_len),      32'(t.el));
                    chk("ovf", 32'(line_overflow), 32'(t.eo));
                end
            end
            if (t.cr) begin
                chk("rd_data", 32'(rd_data), 32'(t.ed));
            end
        end

        // twenty 'a' then CR: truncated to 16
        cur_row = 1000;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 8'h61, 1'b0, 1'b0, 4'd0);
        end
        chk("ovf_valid_before_cr", 32'(line_valid), 32'd0);
        drive(1'b0, 1'b1, K_CR, 1'b0, 1'b0, 4'd0);
        chk("ovf_valid", 32'(line_valid),    32'd1);
        chk("ovf_len",   32'(line_len),      32'd16);
        chk("ovf_flag",  32'(line_overflow), 32'd1);
        chk("ovf_ovr",   32'(overrun),       32'd0);
        for (int a = 0; a < 16; a++) begin
            cur_row = 1100 + a;
            drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'(a));
            chk("ovf_rd", 32'(rd_data), 32'h61);
        end
        cur_row = 1200;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd0);
        chk("ovf_ack_valid", 32'(line_valid),    32'd0);
        chk("ovf_ack_flag",  32'(line_overflow), 32'd0);
        chk("ovf_ack_ovr",   32'(overrun),       32'd0);

        // exactly 16 bytes then CR: full but not truncated
        cur_row = 1300;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 4'd0);
        end
        drive(1'b0, 1'b1, K_CR, 1'b0, 1'b0, 4'd15);
        chk("full_valid", 32'(line_valid),    32'd1);
        chk("full_len",   32'(line_len),      32'd16);
        chk("full_ovf",   32'(line_overflow), 32'd0);
        chk("full_rd15",  32'(rd_data),       32'h3F);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd0);
        chk("full_ack_valid", 32'(line_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
